pgm_tx_sched: RTL
=================

// Module: pgm_tx_sched
// PURPOSE
//  Per-packet transmit scheduler for the packet generator. Chooses which of NUM_Q gated traffic
//  classes builds the next packet header, and holds that choice until the packet-end pulse.
//  Classes in SP_MASK take strict priority; the remaining classes share round-robin.
//  Output FIFO back-pressure and a watchdog guard the shared header-read / packet-emit datapath.
// PARAMETERS
//  NUM_Q        8      number of traffic classes (requesters)
//  USEDW_W      8      width of output FIFO used-words count
//  FIFO_THRESH  8'd200 no new grant while fifo_usedw >= this value
//  SP_MASK      8'h00  bit i=1: class i is strict priority; bit i=0: class i is round-robin
//  TIMEOUT_CYC  4096   cycles in WAIT_DONE before forced abort
// PORTS
//  clk          in   1        core clock
//  rst_n        in   1        asynchronous active-low reset
//  test_start   in   1        level; 0 blocks new grants
//  req          in   NUM_Q    per-class token-bucket request (level)
//  gate_open    in   NUM_Q    per-class gate-control state for current slot (level)
//  fifo_usedw   in   USEDW_W  output FIFO fill level
//  pkt_done     in   1        1-cycle pulse: last word of granted packet emitted
//  grant        out  NUM_Q    one-hot 1-cycle grant pulse (to header fetch, emitter, token bucket)
//  grant_id     out  3        index of last grant; held until next grant
//  busy         out  1        1 in GRANT and WAIT_DONE
//  timeout_err  out  1        sticky; set on watchdog abort; cleared only by reset
// BEHAVIOUR
//  Reset values: grant=0, grant_id=0, busy=0, timeout_err=0, rr_ptr=0, wd_cnt=0, state=IDLE.
//  elig[i] = req[i] & gate_open[i] & test_start & (fifo_usedw < FIFO_THRESH); compare unsigned.
//  FSM:
//   IDLE: if |elig -> ARB; else stay.
//   ARB: evaluate elig again (registered pick).
//     If elig is now 0 -> IDLE, no grant. Else latch pick -> GRANT.
//     Pick rule: lowest index among elig & SP_MASK; if none, first elig & ~SP_MASK at or after rr_ptr (wraps).
//   GRANT: grant[pick]=1 for exactly one cycle; grant_id<=pick; busy=1.
//     rr_ptr <= (pick+1) mod NUM_Q, only when pick is a round-robin class.
//     Next state WAIT_DONE; wd_cnt <= 0.
//   WAIT_DONE: busy=1; wd_cnt++ saturating.
//     pkt_done -> IDLE.
//     wd_cnt == TIMEOUT_CYC-1 with no pkt_done -> timeout_err<=1, then IDLE.
//  Latency: elig rises in IDLE -> grant pulse on the 3rd rising edge (IDLE->ARB->GRANT); min 3 cycles between grants.
//  pkt_done outside WAIT_DONE is ignored. pkt_done and timeout in the same cycle: treat as done, no error.
//  test_start falls mid-packet: the current packet completes; no further grants.
//  req/gate drop in WAIT_DONE: no effect on the current packet.
//  Wrap: rr_ptr=NUM_Q-1 and grant at NUM_Q-1 -> rr_ptr=0.
//  Reset mid-operation: immediate return to reset values; the partial packet is owned by downstream.
// STRUCTURE
//  pgm_sched_pkg: state enum {IDLE,ARB,GRANT,WAIT_DONE}, NUM_Q default, index width localparam.
//  Sub-module pgm_rr_pick: combinational; inputs elig, rr_ptr, sp_mask; outputs pick index and valid.
//  Top: FSM, rr_ptr, watchdog, output registers. All outputs registered.
// TESTING
//  1 Single class: req=8'h04, gate=8'hFF, usedw=0 -> grant=8'h04 on 3rd edge; grant_id=2; busy until pkt_done.
//  2 RR fairness: req=8'hFF held, pkt_done 5 cycles after each grant -> grant order 0,1,...,7,0; no repeats.
//  3 Strict priority: SP_MASK=8'h80, req=8'hFF -> class 7 granted every time. Drop req[7] -> RR resumes at rr_ptr.
//  4 Back-pressure: usedw=200 with req=8'h01 -> no grant. usedw=199 -> grant 3 cycles later.
//    usedw crosses 200 during ARB -> return to IDLE, no grant.
//  5 Watchdog: grant, then no pkt_done -> IDLE after TIMEOUT_CYC cycles; timeout_err=1 and stays 1.
//    pkt_done on the final cycle instead -> timeout_err=0.
//  6 Gate/start/reset: gate_open=0 blocks a request; test_start low mid-packet finishes the packet with no new grant.
//    rst_n low in WAIT_DONE -> all outputs 0 asynchronously; rr_ptr=0.

Source files
------------

// File: rtl/pgm_sched_pkg.sv
// Shared constants and state encoding for the packet-generator transmit scheduler.
package pgm_sched_pkg;

    localparam int PGM_NUM_Q = 8;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int PGM_IDX_W = idx_width(PGM_NUM_Q);

    typedef logic [1:0] sched_state_t;

    localparam sched_state_t ST_IDLE      = 2'd0;
    localparam sched_state_t ST_ARB       = 2'd1;
    localparam sched_state_t ST_GRANT     = 2'd2;
    localparam sched_state_t ST_WAIT_DONE = 2'd3;

endpackage

// File: rtl/pgm_rr_pick.sv
// Combinational class picker: lowest-index strict-priority class wins, otherwise the
// first round-robin class at or after rr_ptr, wrapping past the top index.
module pgm_rr_pick
    import pgm_sched_pkg::*;
#(
    parameter int NUM_Q = PGM_NUM_Q,
    parameter int IDX_W = PGM_IDX_W
) (
    input  logic [NUM_Q-1:0] elig,
    input  logic [IDX_W-1:0] rr_ptr,
    input  logic [NUM_Q-1:0] sp_mask,
    output logic [IDX_W-1:0] pick,
    output logic             valid
);

    logic [NUM_Q-1:0] sp_elig;
    logic [NUM_Q-1:0] rr_elig;
    logic             sp_hit;
    logic             rr_hit;
    logic [IDX_W-1:0] sp_idx;
    logic [IDX_W-1:0] rr_idx;

    assign sp_elig = elig & sp_mask;
    assign rr_elig = elig & ~sp_mask;

    // Scan from the top down so the last match written is the lowest index.
    always_comb begin
        sp_hit = 1'b0;
        sp_idx = '0;
        for (int i = NUM_Q - 1; i >= 0; i--) begin
            if (sp_elig[i]) begin
                sp_hit = 1'b1;
                sp_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        int               pos;
        logic [IDX_W-1:0] cand;
        rr_hit = 1'b0;
        rr_idx = '0;
        pos    = 0;
        cand   = '0;
        for (int k = NUM_Q - 1; k >= 0; k--) begin
            pos = int'(rr_ptr) + k;
            if (pos >= NUM_Q) begin
                pos = pos - NUM_Q;
            end
            cand = IDX_W'(pos);
            if (rr_elig[cand]) begin
                rr_hit = 1'b1;
                rr_idx = cand;
            end
        end
    end

    assign valid = sp_hit | rr_hit;
    assign pick  = sp_hit ? sp_idx : rr_idx;

endmodule

// File: rtl/pgm_tx_sched.sv
// Per-packet transmit scheduler: grants one traffic class at a time and holds it until
// pkt_done, with FIFO back-pressure, strict-priority/round-robin arbitration and a watchdog.
module pgm_tx_sched
    import pgm_sched_pkg::*;
#(
    parameter int                   NUM_Q       = PGM_NUM_Q,
    parameter int                   USEDW_W     = 8,
    parameter logic [USEDW_W-1:0]   FIFO_THRESH = 8'd200,
    parameter logic [NUM_Q-1:0]     SP_MASK     = 8'h00,
    parameter int                   TIMEOUT_CYC = 4096
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          test_start,
    input  logic [NUM_Q-1:0]              req,
    input  logic [NUM_Q-1:0]              gate_open,
    input  logic [USEDW_W-1:0]            fifo_usedw,
    input  logic                          pkt_done,
    output logic [NUM_Q-1:0]              grant,
    output logic [idx_width(NUM_Q)-1:0]   grant_id,
    output logic                          busy,
    output logic                          timeout_err,
    output sched_state_t                  state_dbg
);

    localparam int                IDX_W   = idx_width(NUM_Q);
    localparam int                WD_W    = idx_width(TIMEOUT_CYC);
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0]  TOP_IDX = IDX_W'(NUM_Q - 1);

    sched_state_t     state;
    logic [NUM_Q-1:0] elig;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] pick_q;
    logic             pick_valid;
    logic [WD_W-1:0]  wd_cnt;

    assign elig = req & gate_open
                & {NUM_Q{test_start & (fifo_usedw < FIFO_THRESH)}};

    pgm_rr_pick #(
        .NUM_Q (NUM_Q),
        .IDX_W (IDX_W)
    ) u_pick (
        .elig    (elig),
        .rr_ptr  (rr_ptr),
        .sp_mask (SP_MASK),
        .pick    (pick),
        .valid   (pick_valid)
    );

    // Grant/done handshake: grant is a one-cycle pulse that commits the downstream
    // datapath to one packet; the class stays owned until pkt_done is seen in WAIT_DONE
    // (or the watchdog expires). pkt_done in any other state carries no meaning.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            grant       <= '0;
            grant_id    <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            rr_ptr      <= '0;
            pick_q      <= '0;
            wd_cnt      <= '0;
        end else begin
            grant <= '0;
            case (state)
                ST_IDLE: begin
                    if (|elig) begin
                        state <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    // Eligibility is re-checked here; a late back-pressure drop aborts cleanly.
                    if (pick_valid) begin
                        pick_q <= pick;
                        busy   <= 1'b1;
                        state  <= ST_GRANT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    grant    <= NUM_Q'(1) << pick_q;
                    grant_id <= pick_q;
                    if (!SP_MASK[pick_q]) begin
                        rr_ptr <= (pick_q == TOP_IDX) ? '0 : pick_q + 1'b1;
                    end
                    wd_cnt <= '0;
                    state  <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (pkt_done) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (wd_cnt == WD_LAST) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule
